// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the button event decoder.
// Contents:
//   btn_state_e   - decoder FSM states (idle, pressed/holding, long-held)
//   DefTimerW     - hold timer width for the default LONG_CYCLES=500
//   timer_width() - hold timer width for a given long/repeat period pair
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StLong
  } btn_state_e;

  // $clog2(500) for the default LONG_CYCLES/REPEAT_CYCLES pair
  localparam int unsigned DefTimerW = 9;

  // Timer must reach max(long, repeat) - 1 without wrapping.
  function automatic int unsigned timer_width(input int unsigned long_c,
                                              input int unsigned rep_c);
    return $clog2((long_c > rep_c) ? long_c : rep_c);
  endfunction

endpackage

// File: rtl/evt_timer.sv
// evt_timer: clearable up-counter with a terminal-count compare.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-low reset, clears the count
//   i_clr   - synchronous clear (wins over i_en)
//   i_en    - count enable
//   i_term  - terminal value to compare against
//   o_tc    - high while the count equals i_term
module evt_timer
  import btn_pkg::*;
#(
  parameter int unsigned W = DefTimerW
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into one-cycle event pulses
// (press, release, long-press, auto-repeat) plus a wrapping press counter.
// Optional feature macro: BTN_REPEAT_EN
//   defined   - repeat pulses every REPEAT_CYCLES while held after long-press
//   undefined - o_repeat tied to 0, LONG just waits for release
// Ports:
//   i_clk         - block clock, rising edge
//   i_rst         - synchronous active-low reset
//   i_btn_in      - debounced button level, active-high
//   o_press       - pulse on press
//   o_release     - pulse on release
//   o_long_press  - pulse when the hold reaches LONG_CYCLES
//   o_repeat      - pulse every REPEAT_CYCLES after long-press
//   o_held        - high while not idle
//   o_press_cnt   - press count, wraps modulo 2^CNT_W
module btn_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 500,
  parameter int unsigned REPEAT_CYCLES = 100,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_in,
  output logic             o_press,
  output logic             o_release,
  output logic             o_long_press,
  output logic             o_repeat,
  output logic             o_held,
  output logic [CNT_W-1:0] o_press_cnt
);

  localparam int unsigned TimerW = timer_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [TimerW-1:0] TermLong = TimerW'(LONG_CYCLES - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [TimerW-1:0] TermRep = TimerW'(REPEAT_CYCLES - 1);
`endif

  btn_state_e       r_state, w_state_d;
  logic             r_press, w_press_d;
  logic             r_release, w_release_d;
  logic             r_long, w_long_d;
  logic             w_repeat_d;
  logic [CNT_W-1:0] r_press_cnt, w_press_cnt_d;

  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic [TimerW-1:0] w_tmr_term;
  logic              w_tmr_tc;

  evt_timer #(
    .W(TimerW)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .i_term (w_tmr_term),
    .o_tc   (w_tmr_tc)
  );

  // Release is checked before the terminal count so it always wins.
  always_comb begin
    w_state_d     = r_state;
    w_press_d     = 1'b0;
    w_release_d   = 1'b0;
    w_long_d      = 1'b0;
    w_repeat_d    = 1'b0;
    w_press_cnt_d = r_press_cnt;
    w_tmr_clr     = 1'b0;
    w_tmr_en      = 1'b0;
    w_tmr_term    = TermLong;
    unique case (r_state)
      StIdle: begin
        if (i_btn_in) begin
          w_state_d     = StHold;
          w_press_d     = 1'b1;
          w_press_cnt_d = r_press_cnt + CNT_W'(1);
          w_tmr_clr     = 1'b1;
        end
      end
      StHold: begin
        if (!i_btn_in) begin
          w_state_d   = StIdle;
          w_release_d = 1'b1;
        end else if (w_tmr_tc) begin
          w_state_d = StLong;
          w_long_d  = 1'b1;
          w_tmr_clr = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      StLong: begin
        if (!i_btn_in) begin
          w_state_d   = StIdle;
          w_release_d = 1'b1;
        end else begin
`ifdef BTN_REPEAT_EN
          w_tmr_term = TermRep;
          if (w_tmr_tc) begin
            w_repeat_d = 1'b1;
            w_tmr_clr  = 1'b1;
          end else begin
            w_tmr_en = 1'b1;
          end
`else
          // Timer stays frozen: nothing more fires until release.
          w_tmr_en = 1'b0;
`endif
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_press     <= w_press_d;
      r_release   <= w_release_d;
      r_long      <= w_long_d;
      r_press_cnt <= w_press_cnt_d;
    end
  end

`ifdef BTN_REPEAT_EN
  logic r_repeat;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= w_repeat_d;
    end
  end

  assign o_repeat = r_repeat;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = w_repeat_d;
  assign o_repeat        = 1'b0;
`endif

  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long;
  assign o_held       = (r_state != StIdle);
  assign o_press_cnt  = r_press_cnt;

endmodule

// File: doc/btn_event.md
# btn_event

Button event decoder placed downstream of a debouncer, on the same divided clock as the LED controller. It turns a clean, debounced button level into single-cycle event pulses:

- press
- release
- long-press
- auto-repeat

It also keeps a wrapping press counter. Each add/sub button gets its own instance, so the LED logic consumes discrete events instead of raw levels.

## Interface
Parameters:
- LONG_CYCLES, 500: cycles the button must be held, counted from the press pulse, before long_press fires; legal range ≥ 2.
- REPEAT_CYCLES, 100: period of repeat pulses after long_press; legal range ≥ 1.
- CNT_W, 8: width of press_cnt.

Ports:
- clk, in, 1: block clock (divided clock); all logic on rising edge.
- rst, in, 1: reset, synchronous, active-low.
- btn_in, in, 1: debounced button level, active-high, already synchronous to clk.
- press, out, 1: one-cycle pulse on button press.
- release, out, 1: one-cycle pulse on button release.
- long_press, out, 1: one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat, out, 1: one-cycle pulse every REPEAT_CYCLES after long_press.
- held, out, 1: high while the FSM is not IDLE.
- press_cnt, out, CNT_W: number of presses, wrapping modulo 2^CNT_W.

## Operation
- Reset value: while rst=0 at a rising edge, every output clears to 0, the FSM enters IDLE, and the hold timer clears.
- FSM states: IDLE, HOLD, LONG.
  - IDLE to HOLD when btn_in=1: assert press, increment press_cnt, clear the timer.
  - HOLD to IDLE when btn_in=0: assert release.
  - HOLD to LONG when btn_in=1 and the timer reaches LONG_CYCLES-1: assert long_press, clear the timer.
  - LONG to IDLE when btn_in=0: assert release.
  - LONG stays in LONG when btn_in=1 and the timer reaches REPEAT_CYCLES-1: assert repeat, clear the timer.
- Hold timer: width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). It increments every cycle in HOLD/LONG while btn_in=1 and never wraps, because it is cleared at each terminal count.
- Release priority: release outranks long_press/repeat. If btn_in=0 in the cycle the terminal count would be reached, only release fires.
- press_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Pulse exclusivity: at most one of press/release/long_press/repeat is high in any cycle.
- Reset mid-hold: all outputs are 0 the cycle after reset. If btn_in is still 1 when rst returns to 1, that counts as a new press on the next edge.

## Timing
- All outputs are registered.
- press is high in the cycle after the first edge that samples btn_in=1 (latency 1).
- release has the same latency relative to the first edge that samples btn_in=0.
- long_press is high exactly LONG_CYCLES cycles after the press cycle, if btn_in stays 1 throughout.
- repeat fires REPEAT_CYCLES cycles after long_press, then every REPEAT_CYCLES cycles after that.
- held goes high together with press and low together with release.
- press_cnt updates in the same cycle that press is high.

## Configuration
- BTN_REPEAT_EN defined: auto-repeat works as described above.
- BTN_REPEAT_EN undefined:
  - repeat is tied to 0;
  - LONG becomes a wait-for-release state with the timer frozen;
  - REPEAT_CYCLES is ignored;
  - long_press still fires once per hold.

## Structure
- Shared package btn_pkg holds:
  - the state typedef (IDLE/HOLD/LONG);
  - a constant for the default timer width.
- One sub-module, evt_timer: a clearable up-counter with a terminal-count compare. It takes clr, en and a load-free terminal value input, and outputs tc.
- The FSM, the pulse registers and press_cnt stay in btn_event.

## Test plan
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=3, CNT_W=4 unless stated.
- Reset: hold rst=0 with btn_in=1 for 5 cycles → all outputs 0; after rst rises, press fires 1 cycle later and press_cnt=1.
- Short tap: btn_in=1 for 4 cycles → press, then release, with no long_press; held is high for 4 cycles.
- Long hold, BTN_REPEAT_EN defined: btn_in=1 for 20 cycles →
  - press at cycle t;
  - long_press at t+8;
  - repeat at t+11, t+14, t+17;
  - release 1 cycle after btn_in falls.
- Boundary: btn_in falls so that release would land on cycle t+8 → release only, long_press stays 0.
- Wrap: 17 taps → press_cnt reads 0 after the 16th tap and 1 after the 17th.
- BTN_REPEAT_EN undefined, 20-cycle hold → long_press at t+8, repeat never asserted.
